mat_vec_feeder: RTL and testbench
=================================

// Module: mat_vec_feeder
// PURPOSE
//  Read-side sequencer for the GF(2^8) matrix-vector multiplier: walks the row-major matrix RAM and the vector RAM,
//  issuing word addresses and reads, and streams aligned (matrix word, vector word) pairs to the multiplier.
//  Holds the addressing on the initiator side: the vector address wraps at every row boundary and row markers are emitted.
//  Sits between the two synchronous operand RAMs and the mat_vec_mul datapath.
// PARAMETERS
//  MAT_ROW_SIZE   8                          matrix rows (GF(2^8) elements)
//  MAT_COL_SIZE   16                         matrix columns; must equal VEC_SIZE (elaboration error otherwise)
//  VEC_SIZE       16                         vector length in elements
//  N_GF           8                          elements per word; must divide MAT_COL_SIZE
//  PROC_SIZE      N_GF*8                     word width in bits
//  WORDS_PER_ROW  MAT_COL_SIZE/N_GF          derived
//  MAT_WORDS      MAT_ROW_SIZE*WORDS_PER_ROW derived
// PORTS
//  i_clk        in   1                            clock, rising edge
//  i_rst        in   1                            reset, asynchronous, active-high
//  i_start      in   1                            start request, sampled in IDLE only
//  o_busy       out  1                            1 in RUN/DRAIN
//  o_done       out  1                            1-cycle pulse after final pair accepted
//  o_mat_rd_en  out  1                            matrix RAM read enable
//  o_mat_addr   out  max(1,CLOG2(MAT_WORDS))      matrix word address
//  i_mat_rdata  in   PROC_SIZE                    matrix RAM data, 1 cycle after rd_en
//  o_vec_rd_en  out  1                            vector RAM read enable (equals o_mat_rd_en)
//  o_vec_addr   out  max(1,CLOG2(WORDS_PER_ROW))  vector word address
//  i_vec_rdata  in   PROC_SIZE                    vector RAM data, 1 cycle after rd_en
//  o_valid      out  1                            pair available
//  i_ready      in   1                            consumer accepts; transfer = o_valid & i_ready
//  o_mat        out  PROC_SIZE                    matrix word
//  o_vec        out  PROC_SIZE                    vector word
//  o_first      out  1                            pair is word 0 of its row
//  o_last       out  1                            pair is word WORDS_PER_ROW-1 of its row
//  o_row_idx    out  max(1,CLOG2(MAT_ROW_SIZE))   row of current pair
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, buffer empty, in-flight flag 0; takes effect immediately (async).
//  - FSM: IDLE -(i_start)-> RUN -(last address issued)-> DRAIN -(buffer empty & none in flight)-> DONE -> IDLE.
//  - i_start ignored in RUN/DRAIN/DONE; o_done=1 and o_busy=0 only in DONE.
//  - Issue: in RUN, rd_en=1 iff (occupancy + in_flight) < 3, both registered; no combinational path i_ready->rd_en.
//  - Address k = 0..MAT_WORDS-1 in order: mat_addr=k, vec_addr=k mod WORDS_PER_ROW (wraps to 0 each row).
//  - Return: rdata captured one cycle after rd_en into 3-deep FIFO with tags {first,last,row_idx} of address k.
//  - Latency: start sampled at edge E0 -> rd_en/addr 0 after E0 -> o_valid=1 after E2.
//  - Throughput: i_ready held 1 -> one transfer per cycle, MAT_WORDS transfers in MAT_WORDS consecutive cycles.
//  - o_valid/o_mat/o_vec/tags stable while o_valid & !i_ready; never drop, duplicate or reorder pairs.
//  - FIFO never overflows (issue rule); simultaneous push and pop in one cycle keep occupancy unchanged.
//  - WORDS_PER_ROW=1: vec_addr constant 0, o_first=o_last=1 on every pair.
//  - o_mat/o_vec/tags are 0 whenever o_valid=0.
// STRUCTURE
//  - Shared header mat_vec_defs.vh: CLOG2 macro, WORDS_PER_ROW/MAT_WORDS derivation, FSM state encodings
//    (IDLE=0, RUN=1, DRAIN=2, DONE=3).
//  - Sub-module proc_word_fifo: 3-entry first-word-fall-through FIFO, width 2*PROC_SIZE+2+row_idx width,
//    outputs count; reused for result collection.
//  - Top: FSM, address/row counters, in-flight flag, issue logic.
// TESTING (defaults: MAT_WORDS=16, WORDS_PER_ROW=2)
//  1. RAM mat[k]={8{k[7:0]}}, vec[j]={8{8'hA0+j}}, i_ready=1 -> 16 back-to-back transfers, o_vec alternates A0../A1..,
//     o_first on even k, o_last on odd k, o_row_idx 0..7, o_done 1 cycle after transfer 15.
//  2. i_ready toggles 1,0,1,0 -> 16 pairs in order k=0..15, no loss/dup, rd_en never high when occupancy+in_flight=3.
//  3. i_ready=0 for 10 cycles after start -> exactly 3 reads issued, o_mat=64'h0 pair k=0 held stable, then drains in order.
//  4. i_start pulsed in RUN and in DONE -> ignored (16 transfers only); new start from IDLE -> second run begins at addr 0.
//  5. i_rst asserted mid-cycle after transfer 5 -> all outputs 0 before next edge; after release, start -> pair k=0 first.
//  6. N_GF=16, MAT_COL_SIZE=VEC_SIZE=16 -> vec_addr always 0, o_first=o_last=1 each pair, 8 transfers, o_row_idx=k.

Source files
------------

// File: rtl/mat_vec_feeder_pkg.sv
// mat_vec_feeder_pkg: shared FSM encoding, FIFO depth and address-width helper for the matrix-vector feeder.
package mat_vec_feeder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam int FIFO_DEPTH = 3;
    function automatic int aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mat_vec_feeder_proc_word_fifo.sv
// proc_word_fifo: 3-entry first-word-fall-through FIFO; o_data reads as 0 while empty.
module proc_word_fifo
    import mat_vec_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == 2'(FIFO_DEPTH - 1)) ? 2'd0 : r_wp + 2'd1;
            if (w_pop) r_rp <= (r_rp == 2'(FIFO_DEPTH - 1)) ? 2'd0 : r_rp + 2'd1;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
    assign o_valid = r_count != 2'd0;
    assign o_data  = o_valid ? r_mem[r_rp] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/mat_vec_feeder.sv
// mat_vec_feeder: walks the row-major matrix RAM and the vector RAM, streaming aligned
// (matrix word, vector word) pairs with row markers to the GF(2^8) multiplier.
module mat_vec_feeder
    import mat_vec_feeder_pkg::*;
#(
    parameter int MAT_ROW_SIZE = 8,
    parameter int MAT_COL_SIZE = 16,
    parameter int VEC_SIZE     = 16,
    parameter int N_GF         = 8,
    parameter int PROC_SIZE    = N_GF * 8,
    localparam int WORDS_PER_ROW = MAT_COL_SIZE / N_GF,
    localparam int MAT_WORDS     = MAT_ROW_SIZE * WORDS_PER_ROW,
    localparam int MAW           = aw(MAT_WORDS),
    localparam int VAW           = aw(WORDS_PER_ROW),
    localparam int RAW           = aw(MAT_ROW_SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_mat_rd_en,
    output logic [MAW-1:0]       o_mat_addr,
    input  logic [PROC_SIZE-1:0] i_mat_rdata,
    output logic                 o_vec_rd_en,
    output logic [VAW-1:0]       o_vec_addr,
    input  logic [PROC_SIZE-1:0] i_vec_rdata,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PROC_SIZE-1:0] o_mat,
    output logic [PROC_SIZE-1:0] o_vec,
    output logic                 o_first,
    output logic                 o_last,
    output logic [RAW-1:0]       o_row_idx
);
    localparam int FW = 2 * PROC_SIZE + 2 + RAW;
    if (MAT_COL_SIZE != VEC_SIZE) begin : g_bad_cols
        $error("mat_vec_feeder: MAT_COL_SIZE must equal VEC_SIZE");
    end
    if ((MAT_COL_SIZE % N_GF) != 0) begin : g_bad_ngf
        $error("mat_vec_feeder: N_GF must divide MAT_COL_SIZE");
    end
    state_t         r_state;
    state_t         w_next;
    logic [MAW-1:0] r_addr;
    logic [VAW-1:0] r_col;
    logic [RAW-1:0] r_row;
    logic [RAW+1:0] r_tag;
    logic           r_in_flight;
    logic [1:0]     w_count;
    logic           w_rd_en;
    logic           w_last_addr;
    logic           w_col_last;
    logic           w_pop;
    logic           w_drained;
    logic           w_fifo_valid;
    logic [FW-1:0]  w_fifo_out;
    assign w_last_addr = r_addr == MAW'(MAT_WORDS - 1);
    assign w_col_last  = r_col == VAW'(WORDS_PER_ROW - 1);
    assign w_pop       = w_fifo_valid && i_ready;
    // Done is entered right after the final pop, so the pulse lands one cycle after the last transfer.
    assign w_drained   = !r_in_flight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_RUN;
            ST_RUN:   if (w_rd_en && w_last_addr) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
        endcase
    end
    // Issue only while committed words (buffered + returning) leave a free FIFO slot.
    always_comb begin
        w_rd_en = (r_state == ST_RUN) && (({1'b0, w_count} + {2'b0, r_in_flight}) < 3'd3);
        o_busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        o_done  = r_state == ST_DONE;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_tag       <= '0;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_rd_en;
            if (w_rd_en) begin
                r_addr <= w_last_addr ? '0 : r_addr + MAW'(1);
                r_col  <= w_col_last ? '0 : r_col + VAW'(1);
                r_tag  <= {r_col == '0, w_col_last, r_row};
                if (w_col_last) r_row <= (r_row == RAW'(MAT_ROW_SIZE - 1)) ? '0 : r_row + RAW'(1);
            end
        end
    end
    proc_word_fifo #(.WIDTH(FW)) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (r_in_flight),
        .i_data ({i_mat_rdata, i_vec_rdata, r_tag}),
        .i_pop  (w_pop),
        .o_valid(w_fifo_valid),
        .o_data (w_fifo_out),
        .o_count(w_count)
    );
    assign o_mat_rd_en = w_rd_en;
    assign o_vec_rd_en = w_rd_en;
    assign o_mat_addr  = r_addr;
    assign o_vec_addr  = r_col;
    assign o_valid     = w_fifo_valid;
    assign {o_mat, o_vec, o_first, o_last, o_row_idx} = w_fifo_out;
endmodule

// File: tb/tb_mat_vec_feeder.sv
// tb_mat_vec_feeder: scoreboard bench for mat_vec_feeder with RAM models and a second N_GF=16 instance.
module tb_mat_vec_feeder;
    typedef struct packed {
        logic [63:0] m;
        logic [63:0] v;
        logic        f;
        logic        l;
        logic [2:0]  r;
    } pair_t;
    logic clk = 1'b0;
    logic rst, start, ready, start2;
    always #5 clk = ~clk;
    logic        busy, done, mat_rd_en, vec_rd_en, valid, first, last;
    logic [3:0]  mat_addr;
    logic [0:0]  vec_addr;
    logic [63:0] mat_rdata, vec_rdata, o_mat, o_vec;
    logic [2:0]  row;
    logic [63:0] mat_mem [16];
    logic [63:0] vec_mem [2];
    logic         busy2, done2, mat_rd_en2, vec_rd_en2, valid2, first2, last2;
    logic [2:0]   mat_addr2, row2;
    logic [0:0]   vec_addr2;
    logic [127:0] mat_rdata2, vec_rdata2, o_mat2, o_vec2;
    logic [127:0] mat_mem2 [8];
    logic [127:0] vec_mem2;
    mat_vec_feeder dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_mat_rd_en(mat_rd_en), .o_mat_addr(mat_addr), .i_mat_rdata(mat_rdata),
        .o_vec_rd_en(vec_rd_en), .o_vec_addr(vec_addr), .i_vec_rdata(vec_rdata),
        .o_valid(valid), .i_ready(ready), .o_mat(o_mat), .o_vec(o_vec),
        .o_first(first), .o_last(last), .o_row_idx(row)
    );
    mat_vec_feeder #(.N_GF(16)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_mat_rd_en(mat_rd_en2), .o_mat_addr(mat_addr2), .i_mat_rdata(mat_rdata2),
        .o_vec_rd_en(vec_rd_en2), .o_vec_addr(vec_addr2), .i_vec_rdata(vec_rdata2),
        .o_valid(valid2), .i_ready(1'b1), .o_mat(o_mat2), .o_vec(o_vec2),
        .o_first(first2), .o_last(last2), .o_row_idx(row2)
    );
    always @(posedge clk) begin
        if (mat_rd_en) mat_rdata <= mat_mem[mat_addr];
        if (vec_rd_en) vec_rdata <= vec_mem[vec_addr];
        if (mat_rd_en2) mat_rdata2 <= mat_mem2[mat_addr2];
        if (vec_rd_en2) vec_rdata2 <= vec_mem2;
    end
    int    n_chk = 0, n_fail = 0;
    pair_t exp_q [$];
    pair_t held, cur, e;
    int    outstanding = 0, rd_cnt = 0, xfers = 0, cyc = 0, first_cyc = 0, last_cyc = 0, k2 = 0;
    logic  done_due = 1'b0, hold = 1'b0;
    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            rd_cnt      = 0;
            done_due    = 1'b0;
            hold        = 1'b0;
            k2          = 0;
        end else begin
            cur = {o_mat, o_vec, first, last, row};
            chk("done_timing", done, done_due);
            done_due = 1'b0;
            chk("vec_rd_en", vec_rd_en, mat_rd_en);
            if (mat_rd_en) begin
                chk("issue_limit", outstanding < 3, 1);
                chk("mat_addr", mat_addr, rd_cnt % 16);
                chk("vec_addr", vec_addr, rd_cnt % 2);
                rd_cnt++;
                outstanding++;
            end
            if (hold) chk("held_pair", {valid, cur}, {1'b1, held});
            hold = valid && !ready;
            held = cur;
            if (!valid) chk("idle_zero", cur, 0);
            else if (ready) begin
                if (exp_q.size() == 0) chk("unexpected_pair", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pair", cur, e);
                    done_due = e.l && (e.r == 3'd7);
                end
                outstanding--;
                if (xfers == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfers++;
            end
            if (mat_rd_en2) chk("n16_vec_addr", vec_addr2, 0);
            if (valid2) begin
                chk("n16_pair", {o_mat2, o_vec2, first2, last2, row2},
                    {mat_mem2[k2 % 8], vec_mem2, 2'b11, 3'(k2)});
                k2++;
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic load(input bit rnd);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            b = 8'(k);
            mat_mem[k] = rnd ? {$urandom, $urandom} : {8{b}};
        end
        for (int j = 0; j < 2; j++) vec_mem[j] = rnd ? {$urandom, $urandom} : {8{8'hA0 + 8'(j)}};
    endtask
    task automatic expect_run();
        for (int k = 0; k < 16; k++) exp_q.push_back({mat_mem[k], vec_mem[k % 2], k % 2 == 0, k % 2 == 1, 3'(k / 2)});
    endtask
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask
    task automatic run_ready(input int mode, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~ready : 1'($urandom_range(0, 1));
            step(1);
            got = done;
        end
        chk({name, "_done_seen"}, got, 1);
    endtask
    initial begin
        int base;
        bit got;
        rst = 1'b1; start = 1'b0; ready = 1'b0; start2 = 1'b0;
        step(2);
        chk("reset_outputs", {busy, done, mat_rd_en, valid, mat_addr, o_mat, row}, 0);
        rst = 1'b0;
        step(1);
        // back-to-back stream with fixed contents, latency and throughput
        load(0);
        expect_run();
        ready = 1'b1;
        xfers = 0;
        pulse_start();
        chk("start_issue", {mat_rd_en, mat_addr, busy}, {1'b1, 4'd0, 1'b1});
        step(1);
        chk("latency_e1", valid, 0);
        step(1);
        chk("latency_e2", valid, 1);
        run_ready(0, "t1");
        chk("t1_count", xfers, 16);
        chk("t1_throughput", last_cyc - first_cyc, 15);
        step(2);
        // alternating backpressure
        load(1);
        expect_run();
        base = xfers;
        pulse_start();
        run_ready(1, "t2");
        chk("t2_count", xfers - base, 16);
        step(2);
        // stalled consumer: only three reads issue
        load(0);
        expect_run();
        ready = 1'b0;
        base = rd_cnt;
        pulse_start();
        step(10);
        chk("t3_reads", rd_cnt - base, 3);
        chk("t3_head", {valid, o_mat}, {1'b1, 64'h0});
        run_ready(0, "t3");
        step(2);
        // starts in RUN and DONE ignored, then a fresh run
        load(1);
        expect_run();
        base = xfers;
        pulse_start();
        step(3);
        pulse_start();
        run_ready(2, "t4a");
        pulse_start();
        step(4);
        chk("t4_ignored", {busy, xfers - base}, {1'b0, 32'd16});
        expect_run();
        pulse_start();
        chk("t4_restart", {mat_rd_en, mat_addr}, {1'b1, 4'd0});
        run_ready(2, "t4b");
        step(2);
        // async reset mid-run
        load(1);
        expect_run();
        ready = 1'b1;
        base = xfers;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step(1);
            got = (xfers - base) >= 6;
        end
        chk("t5_reached", got, 1);
        #2 rst = 1'b1;
        #1 chk("t5_async_reset", {busy, done, mat_rd_en, valid, mat_addr, vec_addr, o_mat, o_vec, first, last, row}, 0);
        step(2);
        rst = 1'b0;
        step(1);
        expect_run();
        pulse_start();
        run_ready(2, "t5");
        step(2);
        // one word per row instance
        for (int k = 0; k < 8; k++) mat_mem2[k] = {$urandom, $urandom, $urandom, $urandom};
        vec_mem2 = {$urandom, $urandom, $urandom, $urandom};
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step(1);
            got = done2;
        end
        chk("n16_done_seen", got, 1);
        chk("n16_count", k2, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
